// File: rtl/ntt_seq_ctrl_pkg.sv
// Shared defaults and the controller state encoding for the sequenced NTT engine.
// Holds no logic and therefore adds no latency.
// Has no handshake of its own, so it applies no backpressure.
package ntt_pkg;

  localparam int NTT_N  = 32;
  localparam int NTT_DW = 4;
  localparam int NTT_QW = 8;
  localparam int NTT_WW = 5;
  localparam int NTT_CW = $clog2(NTT_N);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LOAD    = 2'd1,
    COMPUTE = 2'd2,
    EMIT    = 2'd3
  } state_t;

endpackage

// File: rtl/ntt_modmul.sv
// Combinational modular multiply r = (a*b) mod q, formed at full product width.
// Latency is 0 cycles: the result settles in the same cycle as the operands.
// Has no handshake, so it applies no backpressure. A q of 0 yields 0 rather than X.
module ntt_modmul #(
  parameter int AW = 4,
  parameter int BW = 8,
  parameter int QW = 8
) (
  input  logic [AW-1:0] a,
  input  logic [BW-1:0] b,
  input  logic [QW-1:0] q,
  output logic [QW-1:0] r
);

  localparam int PW = AW + BW;

  logic [PW-1:0] prod;
  logic [PW-1:0] q_ext;

  // Full-width product, then reduction; the remainder always fits in QW bits.
  always_comb begin
    prod  = PW'(a) * PW'(b);
    q_ext = PW'(q);
    r     = (q == '0) ? '0 : QW'(prod % q_ext);
  end

endmodule

// File: rtl/ntt_seq_ctrl.sv
// Sequenced NTT controller: loads N coefficients, runs N*N shared MACs, and streams out N results.
// Latency from the first beat to the out_last handshake is N + N*(N+1) cycles with out_ready held high.
// in_ready drops during COMPUTE and EMIT; a low out_ready holds EMIT for any number of cycles without losing state.
module ntt_seq_ctrl
  import ntt_pkg::*;
#(
  parameter int N  = NTT_N,
  parameter int DW = NTT_DW,
  parameter int QW = NTT_QW,
  parameter int WW = NTT_WW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_data,
  input  logic [QW-1:0] q,
  input  logic [WW-1:0] w,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [QW-1:0] out_data,
  output logic          out_last,
  output logic          busy,
  output logic          cfg_err
);

  localparam int CW = $clog2(N);
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  state_t        state, state_nx;
  logic [DW-1:0] coef [N];
  logic [CW-1:0] ld_cnt, i_cnt, j_cnt, wr_idx;
  logic [QW-1:0] q_r, w_r, acc, tw, wi;
  logic [QW-1:0] w_mod, one_q, p_mac, p_tw, acc_nx, mul2_a, mul2_b;
  logic [QW:0]   acc_sum;
  logic          accept;

  // The raw root is reduced as it is latched so every later product sees an operand below q.
  assign w_mod  = (q == '0) ? '0 : QW'(QW'(w) % q);
  assign one_q  = (q_r > QW'(1)) ? QW'(1) : '0;
  assign accept = in_valid && ((state == IDLE) || (state == LOAD));
  assign wr_idx = (state == IDLE) ? '0 : ld_cnt;

  // The second multiplier serves tw*wi while computing and wi*w while emitting, when the MAC is idle.
  assign mul2_a = (state == EMIT) ? wi  : tw;
  assign mul2_b = (state == EMIT) ? w_r : wi;

  ntt_modmul #(.AW(DW), .BW(QW), .QW(QW)) u_mac_mul (
    .a(coef[j_cnt]), .b(tw), .q(q_r), .r(p_mac)
  );

  ntt_modmul #(.AW(QW), .BW(QW), .QW(QW)) u_tw_mul (
    .a(mul2_a), .b(mul2_b), .q(q_r), .r(p_tw)
  );

  // Both addends are already below q, so a single conditional subtract completes the reduction.
  always_comb begin
    acc_sum = {1'b0, acc} + {1'b0, p_mac};
    acc_nx  = (acc_sum >= {1'b0, q_r}) ? QW'(acc_sum - {1'b0, q_r}) : acc_sum[QW-1:0];
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // Next-state and handshake outputs; in_ready is forced low while reset is held.
  always_comb begin
    state_nx  = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    unique case (state)
      IDLE: begin
        in_ready = rst_n;
        if (in_valid) state_nx = LOAD;
      end
      LOAD: begin
        in_ready = rst_n;
        if (in_valid && (ld_cnt == LAST)) state_nx = COMPUTE;
      end
      COMPUTE: begin
        if (j_cnt == LAST) state_nx = EMIT;
      end
      EMIT: begin
        out_valid = 1'b1;
        if (out_ready) state_nx = (i_cnt == LAST) ? IDLE : COMPUTE;
      end
      default: state_nx = IDLE;
    endcase
    busy     = (state != IDLE);
    out_data = out_valid ? acc : '0;
    out_last = out_valid && (i_cnt == LAST);
  end

  // Coefficient store; contents are not reset because a new frame always overwrites every entry.
  always_ff @(posedge clk) begin
    if (accept) coef[wr_idx] <= in_data;
  end

  // Frame configuration, counters and the MAC/twiddle datapath.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_r     <= '0;
      w_r     <= '0;
      ld_cnt  <= '0;
      i_cnt   <= '0;
      j_cnt   <= '0;
      acc     <= '0;
      tw      <= '0;
      wi      <= '0;
      cfg_err <= 1'b0;
    end else begin
      cfg_err <= 1'b0;
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            q_r     <= q;
            w_r     <= w_mod;
            ld_cnt  <= CW'(1);
            cfg_err <= (q < QW'(2));
          end
        end
        LOAD: begin
          if (in_valid) begin
            ld_cnt <= ld_cnt + CW'(1);
            if (ld_cnt == LAST) begin
              i_cnt <= '0;
              j_cnt <= '0;
              acc   <= '0;
              wi    <= one_q;
              tw    <= one_q;
            end
          end
        end
        COMPUTE: begin
          acc   <= acc_nx;
          tw    <= p_tw;
          j_cnt <= j_cnt + CW'(1);
        end
        EMIT: begin
          if (out_ready && (i_cnt != LAST)) begin
            i_cnt <= i_cnt + CW'(1);
            wi    <= p_tw;
            tw    <= one_q;
            acc   <= '0;
            j_cnt <= '0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
